param_datapath: RTL
===================

Name: param_datapath

Overview:
- Next-generation processor datapath: a parametrised register file, a two-operand ALU and a status-flag register behind a single-issue micro-op interface.
- One micro-op is accepted per cycle. Execution takes one pipeline stage, with writeback and bypass forwarding.
- Sits between the control unit/decoder (which drives micro-ops) and the top-level core.
- A debug read port lets benches inspect architectural state.

Parameters:
- WIDTH, 16, data path and register width in bits (≥4).
- NREGS, 8, number of registers (power of two, ≥2). Derived localparam RAW = $clog2(NREGS).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- op_valid  input  1  micro-op present.
- op_ready  output  1  datapath can accept a micro-op this cycle.
- op_code  input  4  operation select (see Behaviour).
- op_dst  input  RAW  destination register.
- op_srca  input  RAW  source A register.
- op_srcb  input  RAW  source B register.
- op_use_imm  input  1  1: operand B = op_imm; 0: operand B = R[op_srcb].
- op_imm  input  WIDTH  immediate operand.
- res_valid  output  1  one-cycle pulse per completed micro-op.
- res_we  output  1  completed micro-op wrote op_dst.
- res_dst  output  RAW  destination of the completed micro-op.
- res_data  output  WIDTH  ALU result of the completed micro-op.
- flags  output  4  {Z,N,C,V} status register.
- dbg_addr  input  RAW  debug register select.
- dbg_data  output  WIDTH  R[dbg_addr]; combinational, post-writeback.

Behaviour:
- Reset: all registers, flags, res_valid, res_we, res_dst and res_data go to 0, and op_ready goes to 1. Any in-flight micro-op, including a MUL in progress, is discarded with no writeback.
- Acceptance: a micro-op is accepted on an edge where op_valid & op_ready is high. Operands are read combinationally in the acceptance cycle and captured with op/dst into the EX stage.
- Latency: a micro-op accepted at edge T writes back at edge T+1. From T+1 onward, res_* and flags are visible and the regfile is updated. Back-to-back issue is allowed every cycle.
- Bypass: if the EX stage holds a writing micro-op whose dst equals srca/srcb, the ALU result is forwarded to that operand.
- Carry bypass: ADC takes carry-in from the EX stage's new C when that micro-op updates C; otherwise from the flags register.
- R0 reads as 0 and writes to R0 are dropped. res_we still reflects the opcode; res_data still carries the result.
- Opcodes:
  - 0 ADD, 1 SUB (A−B), 10 ADC: write; update Z,N,C,V. C is the carry-out for ADD/ADC and the borrow-free indicator (A≥B unsigned) for SUB. V is two's-complement overflow.
  - 9 CMP: computes SUB, updates Z,N,C,V, no write.
  - 2 AND, 3 OR, 4 XOR, 5 NOT A, 8 MOV B: write; update Z,N; C,V unchanged.
  - 6 SHL, 7 SHR (logical): shift A by B[RAW_S-1:0], where RAW_S = $clog2(WIDTH). Write; update Z,N.
  - 11 MUL: see Optional Feature.
  - 12–15 NOP: no write, no flag change, but res_valid still pulses with res_we=0.
- Width rules: all arithmetic is modulo 2^WIDTH. Z = (result==0); N = result[WIDTH-1].
- Outputs are registered. res_valid is low in cycles with no completion.
- op_ready is 1 at all times, except during an iterative MUL.

Optional Feature:
- Macro: DATAPATH_MUL_EN.
- Defined: opcode 11 MUL computes the low WIDTH bits of the unsigned A×B with an iterative shift-add FSM (IDLE → MUL → IDLE).
  - Accepted at T: op_ready is 0 from T until writeback, and the product is written back at edge T+WIDTH.
  - res_valid pulses once. Z,N are updated; C,V are unchanged.
  - op_ready returns to 1 in the cycle after writeback. Bypass into MUL operands applies as for other ops.
  - rst during the MUL state aborts the multiply: no write, no flag change.
- Undefined: opcode 11 behaves as NOP and op_ready stays at constant 1.

Test Plan:
- Reset then load: MOV imm 0x1234→R1, MOV imm 0xFFFF→R2 -> dbg R1=0x1234, R2=0xFFFF; Z=0, N=1 after the second op.
- Back-to-back bypass: ADD R3=R1+R2 followed next cycle by ADD R4=R3+R1 -> R3=0x1233 with C=1; R4=0x2467.
- Flags: SUB R5 = 0x8000 − 0x0001 -> 0x7FFF, V=1, C=1, N=0; CMP R1,R1 -> Z=1, R0–R7 unchanged, res_we=0.
- ADC carry bypass: ADD 0xFFFF+0x0001 (C→1) immediately followed by ADC 0x0000+0x0000 -> result 0x0001.
- R0/NOP/shift: MOV imm 5→R0 -> dbg R0=0; SHL R1 by imm 4 -> 0x2340; opcode 13 -> res_valid=1, res_we=0, flags unchanged.
- With DATAPATH_MUL_EN: MUL 0x0003×0x0005 -> op_ready low 16 cycles, result 0x000F. Repeat with rst asserted mid-multiply -> no writeback, op_ready=1 the cycle after rst.

Source files
------------

// File: rtl/param_datapath.sv
`default_nettype none
// ============================================================================
// Module   : param_datapath
// Purpose  : Single-issue processor datapath. It holds a parametrised register
//            file, a two-operand ALU with a {Z,N,C,V} status register, and one
//            execute stage that writes back on the next edge. The ALU result
//            is bypassed to a micro-op issued directly behind its producer.
//            The optional iterative shift-add multiplier (opcode 11) is
//            enabled by defining the DATAPATH_MUL_EN macro. When the macro is
//            undefined, opcode 11 acts as a NOP and op_ready is tied high.
// Ports    : clk, rst              clock, synchronous active-high reset
//            op_*                  micro-op issue (valid/ready handshake)
//            res_*                 registered completion report, one per op
//            flags                 {Z,N,C,V} status register
//            dbg_addr / dbg_data   combinational register-file read
// Revision : 1.0 - initial release
// ============================================================================
module param_datapath #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic [3:0]               op_code,
    input  logic [$clog2(NREGS)-1:0] op_dst,
    input  logic [$clog2(NREGS)-1:0] op_srca,
    input  logic [$clog2(NREGS)-1:0] op_srcb,
    input  logic                     op_use_imm,
    input  logic [WIDTH-1:0]         op_imm,
    output logic                     res_valid,
    output logic                     res_we,
    output logic [$clog2(NREGS)-1:0] res_dst,
    output logic [WIDTH-1:0]         res_data,
    output logic [3:0]               flags,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [WIDTH-1:0]         dbg_data
);
    localparam int RAW   = $clog2(NREGS);
    localparam int RAW_S = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3,  OP_XOR = 4'd4,  OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6,  OP_SHR = 4'd7,  OP_MOV = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9,  OP_ADC = 4'd10, OP_MUL = 4'd11;

    logic [WIDTH-1:0] r_rf [NREGS];

    // Execute stage
    logic             r_ex_valid;
    logic [3:0]       r_ex_op;
    logic [RAW-1:0]   r_ex_dst;
    logic [WIDTH-1:0] r_ex_a, r_ex_b;

    logic             w_accept, w_is_mul;
    logic [WIDTH-1:0] w_opa, w_opb;
    logic             w_fwd;

    // ALU
    logic [WIDTH:0]   w_sum, w_diff;
    logic             w_cin;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_we, w_upd_zn, w_upd_cv, w_alu_c, w_alu_v;

    // Completion (EX stage or multiplier) feeding writeback
    logic             w_cmp_valid, w_cmp_we, w_cmp_upd_zn, w_cmp_upd_cv;
    logic [RAW-1:0]   w_cmp_dst;
    logic [WIDTH-1:0] w_cmp_data;

    assign w_accept = op_valid & op_ready;

    // Operand read with forwarding from the EX-stage producer. R0 is hard zero.
    assign w_fwd = r_ex_valid & w_alu_we;
    assign w_opa = (op_srca == '0) ? '0 :
                   (w_fwd && r_ex_dst == op_srca) ? w_alu_res : r_rf[op_srca];
    assign w_opb = op_use_imm ? op_imm :
                   (op_srcb == '0) ? '0 :
                   (w_fwd && r_ex_dst == op_srcb) ? w_alu_res : r_rf[op_srcb];

    // The producer of any earlier carry commits its flags on the same edge
    // that ADC enters EX, so the flags register already holds the bypassed C.
    assign w_cin  = (r_ex_op == OP_ADC) & flags[1];
    assign w_sum  = {1'b0, r_ex_a} + {1'b0, r_ex_b} + {{WIDTH{1'b0}}, w_cin};
    assign w_diff = {1'b0, r_ex_a} - {1'b0, r_ex_b};

    always_comb begin
        w_alu_res = '0;
        w_alu_we  = 1'b0;
        w_upd_zn  = 1'b0;
        w_upd_cv  = 1'b0;
        w_alu_c   = flags[1];
        w_alu_v   = flags[0];
        case (r_ex_op)
            OP_ADD, OP_ADC: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_we  = 1'b1;
                w_upd_zn  = 1'b1;
                w_upd_cv  = 1'b1;
                w_alu_c   = w_sum[WIDTH];
                w_alu_v   = (r_ex_a[WIDTH-1] == r_ex_b[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != r_ex_a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                w_alu_res = w_diff[WIDTH-1:0];
                w_alu_we  = (r_ex_op == OP_SUB);
                w_upd_zn  = 1'b1;
                w_upd_cv  = 1'b1;
                w_alu_c   = ~w_diff[WIDTH];   // no borrow: A >= B unsigned
                w_alu_v   = (r_ex_a[WIDTH-1] != r_ex_b[WIDTH-1]) &&
                            (w_diff[WIDTH-1] != r_ex_a[WIDTH-1]);
            end
            OP_AND: begin w_alu_res = r_ex_a & r_ex_b; w_alu_we = 1'b1; w_upd_zn = 1'b1; end
            OP_OR:  begin w_alu_res = r_ex_a | r_ex_b; w_alu_we = 1'b1; w_upd_zn = 1'b1; end
            OP_XOR: begin w_alu_res = r_ex_a ^ r_ex_b; w_alu_we = 1'b1; w_upd_zn = 1'b1; end
            OP_NOT: begin w_alu_res = ~r_ex_a;         w_alu_we = 1'b1; w_upd_zn = 1'b1; end
            OP_MOV: begin w_alu_res = r_ex_b;          w_alu_we = 1'b1; w_upd_zn = 1'b1; end
            OP_SHL: begin
                w_alu_res = r_ex_a << r_ex_b[RAW_S-1:0];
                w_alu_we  = 1'b1;
                w_upd_zn  = 1'b1;
            end
            OP_SHR: begin
                w_alu_res = r_ex_a >> r_ex_b[RAW_S-1:0];
                w_alu_we  = 1'b1;
                w_upd_zn  = 1'b1;
            end
            default: ;   // NOP (and MUL when the multiplier is absent)
        endcase
    end

`ifdef DATAPATH_MUL_EN
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;
    state_t r_state, w_state_next;

    logic [WIDTH-1:0] r_mul_a, r_mul_b, r_mul_acc, w_mul_acc_next;
    logic [CNT_W-1:0] r_mul_cnt;
    logic [RAW-1:0]   r_mul_dst;
    logic             w_mul_done;

    assign w_is_mul       = (op_code == OP_MUL);
    assign op_ready       = (r_state == S_IDLE);
    assign w_mul_acc_next = r_mul_acc + (r_mul_b[0] ? r_mul_a : '0);
    // One partial product per cycle; the last one is written back directly.
    assign w_mul_done     = (r_state == S_MUL) && (r_mul_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_is_mul) w_state_next = S_MUL;
            S_MUL:   if (w_mul_done)           w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mul_a   <= '0;
            r_mul_b   <= '0;
            r_mul_acc <= '0;
            r_mul_cnt <= '0;
            r_mul_dst <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_accept && w_is_mul) begin
                r_mul_a   <= w_opa;
                r_mul_b   <= w_opb;
                r_mul_acc <= '0;
                r_mul_cnt <= '0;
                r_mul_dst <= op_dst;
            end
        end else begin
            r_mul_acc <= w_mul_acc_next;
            r_mul_a   <= r_mul_a << 1;
            r_mul_b   <= r_mul_b >> 1;
            r_mul_cnt <= r_mul_cnt + 1'b1;
        end
    end
`else
    assign w_is_mul = 1'b0;
    assign op_ready = 1'b1;
`endif

    always_comb begin
        w_cmp_valid  = r_ex_valid;
        w_cmp_we     = r_ex_valid & w_alu_we;
        w_cmp_upd_zn = r_ex_valid & w_upd_zn;
        w_cmp_upd_cv = r_ex_valid & w_upd_cv;
        w_cmp_dst    = r_ex_dst;
        w_cmp_data   = w_alu_res;
`ifdef DATAPATH_MUL_EN
        // EX is empty while the multiplier runs, so the two never collide.
        if (w_mul_done) begin
            w_cmp_valid  = 1'b1;
            w_cmp_we     = 1'b1;
            w_cmp_upd_zn = 1'b1;
            w_cmp_upd_cv = 1'b0;
            w_cmp_dst    = r_mul_dst;
            w_cmp_data   = w_mul_acc_next;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
            r_ex_valid <= 1'b0;
            r_ex_op    <= '0;
            r_ex_dst   <= '0;
            r_ex_a     <= '0;
            r_ex_b     <= '0;
            res_valid  <= 1'b0;
            res_we     <= 1'b0;
            res_dst    <= '0;
            res_data   <= '0;
            flags      <= '0;
        end else begin
            r_ex_valid <= w_accept & ~w_is_mul;
            if (w_accept) begin
                r_ex_op  <= op_code;
                r_ex_dst <= op_dst;
                r_ex_a   <= w_opa;
                r_ex_b   <= w_opb;
            end
            res_valid <= w_cmp_valid;
            res_we    <= w_cmp_we;
            if (w_cmp_valid) begin
                res_dst  <= w_cmp_dst;
                res_data <= w_cmp_data;
            end
            if (w_cmp_we && w_cmp_dst != '0) r_rf[w_cmp_dst] <= w_cmp_data;
            if (w_cmp_upd_zn) flags[3:2] <= {(w_cmp_data == '0), w_cmp_data[WIDTH-1]};
            if (w_cmp_upd_cv) flags[1:0] <= {w_alu_c, w_alu_v};
        end
    end

    assign dbg_data = (dbg_addr == '0) ? '0 : r_rf[dbg_addr];

endmodule
`default_nettype wire
